// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader that streams an image into RAM.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam logic [7:0] LOADER_FILL_BYTE = 8'h00;

endpackage

// File: rtl/program_loader_if.sv
// Byte-source handshake, RAM write port and CPU control signals of the program loader.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    modport master (
        input  start, in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );

    modport slave (
        output start, in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Streams a program image into RAM while holding the CPU in reset, zero-fills the tail,
// then releases the CPU. All outputs are registered and decoded from the next state.
import loader_pkg::*;

module program_loader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter bit          CLEAR_TAIL = 1'b1
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.master bus
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(MEM_DEPTH - 1);

    loader_state_t     state, state_d;
    logic [ADDR_W:0]   cnt, cnt_d, cnt_inc;
    logic              xfer;
    logic              in_ready_q, mem_we_q, cpu_reset_q, done_q, error_q;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    assign cnt_inc = cnt + (ADDR_W+1)'(1);
    assign xfer    = bus.in_valid & in_ready_q;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt[ADDR_W-1:0];
                    mem_wdata_d = bus.in_data;
                    cnt_d       = cnt_inc;
                    // A last byte landing on the final address is a clean fit, not an overflow.
                    if (bus.in_last)
                        state_d = (CLEAR_TAIL && (cnt_inc < DEPTH_C)) ? S_CLEAR : S_RELEASE;
                    else if (cnt == LAST_C)
                        state_d = S_ERROR;
                end
            end
            S_CLEAR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = cnt[ADDR_W-1:0];
                mem_wdata_d = DATA_W'(LOADER_FILL_BYTE);
                cnt_d       = cnt_inc;
                if (cnt == LAST_C)
                    state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            in_ready_q  <= (state_d == S_LOAD);
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERROR);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: RAM model fed from the write port, scenario tasks check results.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    program_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    program_loader #(
        .ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256), .CLEAR_TAIL(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [256];
    logic [7:0] img [300];
    int         wr_count;
    int         seq_err;
    logic [8:0] exp_addr;

    // Writes must arrive at strictly consecutive addresses: catches duplicates and drops.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if ({1'b0, bus.mem_addr} !== exp_addr) seq_err++;
            exp_addr = {1'b0, bus.mem_addr} + 9'd1;
            ram[bus.mem_addr] = bus.mem_wdata;
            wr_count++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic prefill();
        for (int i = 0; i < 256; i++) ram[i] = 8'hFF;
        wr_count = 0;
        seq_err  = 0;
        exp_addr = '0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic stream(input int n, input bit with_last, input bit gappy,
                          input int budget, output int accepted);
        int  cyc;
        bit  x;
        cyc = 0;
        accepted = 0;
        while (accepted < n && cyc < budget) begin
            bus.in_valid = gappy ? ((cyc % 2) == 0) : 1'b1;
            bus.in_data  = img[accepted];
            bus.in_last  = with_last && (accepted == n - 1);
            x = bus.in_valid && bus.in_ready;
            step();
            cyc++;
            if (x) accepted++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int t_last, output int t_done);
        t_last = -1;
        t_done = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (bus.mem_we === 1'b1 && bus.mem_addr === 8'hFF) t_last = k;
            if (bus.done === 1'b1) begin
                t_done = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_vec++; if (bus.cpu_reset !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_reset got %b want 1", bus.cpu_reset); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_vec++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
        n_vec++; if (bus.mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_mem_addr got %h want 00", bus.mem_addr); end
        n_vec++; if (bus.mem_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_mem_wdata got %h want 00", bus.mem_wdata); end
        n_vec++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_done_error got %b%b want 00", bus.done, bus.error); end
        reset = 1'b0;
        prefill();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        repeat (3) step();
        bus.in_valid = 1'b0;
        n_vec++; if (wr_count !== 0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ignores_valid got writes=%0d ready=%b want 0 0", wr_count, bus.in_ready); end
    endtask

    task automatic test_small_image();
        int acc, t_last, t_done, nz;
        prefill();
        img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3;
        pulse_start();
        stream(3, 1'b1, 1'b0, 20, acc);
        n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL small_ready_after_last got %b want 0", bus.in_ready); end
        wait_done(300, t_last, t_done);
        n_vec++; if (acc !== 3) begin n_bad++; $display("FAIL small_accepted got %0d want 3", acc); end
        n_vec++; if ({ram[0], ram[1], ram[2]} !== 24'hA1B2C3) begin n_bad++; $display("FAIL small_image got %h want a1b2c3", {ram[0], ram[1], ram[2]}); end
        nz = 0;
        for (int i = 3; i < 256; i++) if (ram[i] !== 8'h00) nz++;
        n_vec++; if (nz !== 0) begin n_bad++; $display("FAIL small_tail_zero got %0d nonzero want 0", nz); end
        n_vec++; if (wr_count !== 256 || seq_err !== 0) begin n_bad++; $display("FAIL small_writes got %0d seqerr=%0d want 256 0", wr_count, seq_err); end
        n_vec++; if (t_done < 0 || t_done - t_last !== 1) begin n_bad++; $display("FAIL small_release_gap got last=%0d done=%0d want gap 1", t_last, t_done); end
        n_vec++; if (bus.cpu_reset !== 1'b0 || bus.error !== 1'b0) begin n_bad++; $display("FAIL small_released got cpu_reset=%b error=%b want 0 0", bus.cpu_reset, bus.error); end
    endtask

    task automatic test_gappy_reload();
        int acc, t_last, t_done;
        prefill();
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        pulse_start();
        n_vec++; if (bus.done !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reload_enter got done=%b cpu_reset=%b ready=%b want 0 1 1", bus.done, bus.cpu_reset, bus.in_ready); end
        stream(4, 1'b1, 1'b1, 40, acc);
        wait_done(300, t_last, t_done);
        n_vec++; if (acc !== 4) begin n_bad++; $display("FAIL gappy_accepted got %0d want 4", acc); end
        n_vec++; if ({ram[0], ram[1], ram[2], ram[3], ram[4]} !== 40'h1122334400) begin n_bad++; $display("FAIL gappy_image got %h want 1122334400", {ram[0], ram[1], ram[2], ram[3], ram[4]}); end
        n_vec++; if (wr_count !== 256 || seq_err !== 0) begin n_bad++; $display("FAIL gappy_writes got %0d seqerr=%0d want 256 0", wr_count, seq_err); end
        n_vec++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL gappy_done got %b want 1", bus.done); end
    endtask

    task automatic test_full_image();
        int acc, bad;
        prefill();
        for (int i = 0; i < 300; i++) img[i] = 8'(i) ^ 8'h5A;
        pulse_start();
        stream(256, 1'b1, 1'b0, 300, acc);
        n_vec++; if (bus.done !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.mem_addr !== 8'hFF) begin n_bad++; $display("FAIL full_release_cycle got done=%b cpu_reset=%b addr=%h want 0 1 ff", bus.done, bus.cpu_reset, bus.mem_addr); end
        step();
        n_vec++; if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL full_done got done=%b error=%b we=%b want 1 0 0", bus.done, bus.error, bus.mem_we); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== (8'(i) ^ 8'h5A)) bad++;
        n_vec++; if (bad !== 0 || wr_count !== 256 || seq_err !== 0) begin n_bad++; $display("FAIL full_image got bad=%0d writes=%0d seqerr=%0d want 0 256 0", bad, wr_count, seq_err); end
    endtask

    task automatic test_overflow();
        int acc;
        prefill();
        pulse_start();
        stream(257, 1'b0, 1'b0, 300, acc);
        n_vec++; if (acc !== 256) begin n_bad++; $display("FAIL ovf_accepted got %0d want 256", acc); end
        n_vec++; if (wr_count !== 256 || seq_err !== 0) begin n_bad++; $display("FAIL ovf_writes got %0d seqerr=%0d want 256 0", wr_count, seq_err); end
        n_vec++; if (bus.error !== 1'b1 || bus.cpu_reset !== 1'b1 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL ovf_state got err=%b cpu_reset=%b ready=%b done=%b want 1 1 0 0", bus.error, bus.cpu_reset, bus.in_ready, bus.done); end
        pulse_start();
        n_vec++; if (bus.error !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_restart got err=%b ready=%b want 0 1", bus.error, bus.in_ready); end
    endtask

    task automatic test_reset_midload();
        int acc;
        prefill();
        stream(5, 1'b0, 1'b0, 20, acc);
        n_vec++; if (acc !== 5 || bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h04) begin n_bad++; $display("FAIL mid_before got acc=%0d we=%b addr=%h want 5 1 04", acc, bus.mem_we, bus.mem_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++; if (bus.cpu_reset !== 1'b1 || bus.mem_we !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset got cpu_reset=%b we=%b done=%b ready=%b want 1 0 0 0", bus.cpu_reset, bus.mem_we, bus.done, bus.in_ready); end
        step();
        n_vec++; if (bus.in_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin n_bad++; $display("FAIL mid_idle got ready=%b cpu_reset=%b want 0 1", bus.in_ready, bus.cpu_reset); end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        prefill();
        test_reset();
        test_small_image();
        test_gappy_reload();
        test_full_image();
        test_overflow();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
